// File: rtl/pwm_param_ctrl.sv
// Push-button front end for the PWM generator: synchronises and debounces two keys,
// steps frequency or duty once per press with auto-repeat, saturates, and strobes changes.
module pwm_param_ctrl #(
  parameter int SYSCLK_FRQ   = 50000000,
  parameter int freq_min     = 1,
  parameter int freq_max     = 10000,
  parameter int nbits_freq   = $clog2(freq_max + 1),
  parameter int FREQ_INIT    = 1000,
  parameter int DUTY_INIT    = 50,
  parameter int DEB_MS       = 20,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100,
  parameter int FSTEP_FINE   = 1,
  parameter int FSTEP_COARSE = 100,
  parameter int DSTEP_FINE   = 1,
  parameter int DSTEP_COARSE = 10
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iKEY_UP,
  input  logic                  iKEY_DN,
  input  logic                  iMODE,
  input  logic                  iCOARSE,
  output logic [nbits_freq-1:0] oPWM_freq,
  output logic [6:0]            oduty_cycle,
  output logic                  oUPD
);

  localparam int MS_CYC    = SYSCLK_FRQ / 1000;
  localparam int DEB_CYC   = DEB_MS * MS_CYC;
  localparam int DELAY_CYC = REP_DELAY_MS * MS_CYC;
  localparam int RATE_CYC  = REP_RATE_MS * MS_CYC;
  localparam int DEB_W     = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam int TMR_MAX   = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
  localparam int FW        = nbits_freq + 1;

  // The timer counts down to zero, so loads are one short of the period.
  localparam logic [DEB_W-1:0] DEB_TOP  = DEB_W'((DEB_CYC > 1) ? DEB_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] DELAY_LD = TMR_W'((DELAY_CYC > 1) ? DELAY_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] RATE_LD  = TMR_W'((RATE_CYC > 1) ? RATE_CYC - 1 : 0);

  localparam int FREQ_RST_I = (FREQ_INIT < freq_min) ? freq_min :
                              (FREQ_INIT > freq_max) ? freq_max : FREQ_INIT;
  localparam int DUTY_RST_I = (DUTY_INIT < 0) ? 0 : (DUTY_INIT > 100) ? 100 : DUTY_INIT;
  localparam logic [nbits_freq-1:0] FREQ_RST = nbits_freq'(FREQ_RST_I);
  localparam logic [6:0]            DUTY_RST = 7'(DUTY_RST_I);

  localparam logic signed [FW-1:0]  FMIN_S   = FW'(freq_min);
  localparam logic signed [FW-1:0]  FMAX_S   = FW'(freq_max);
  localparam logic [nbits_freq-1:0] FMIN_U   = nbits_freq'(freq_min);
  localparam logic [nbits_freq-1:0] FMAX_U   = nbits_freq'(freq_max);
  localparam logic signed [FW-1:0]  FSTEP_F  = FW'(FSTEP_FINE);
  localparam logic signed [FW-1:0]  FSTEP_C  = FW'(FSTEP_COARSE);
  localparam logic signed [7:0]     DSTEP_F  = 8'(DSTEP_FINE);
  localparam logic signed [7:0]     DSTEP_C  = 8'(DSTEP_COARSE);
  localparam logic signed [7:0]     DMAX_S   = 8'sd100;

  typedef enum logic [1:0] {IDLE, FIRE, HOLD, LOCK} state_t;

  function automatic logic [nbits_freq-1:0] sat_freq(input logic signed [FW-1:0] v);
    if (v < FMIN_S)      sat_freq = FMIN_U;
    else if (v > FMAX_S) sat_freq = FMAX_U;
    else                 sat_freq = v[nbits_freq-1:0];
  endfunction

  function automatic logic [6:0] sat_duty(input logic signed [7:0] v);
    if (v < 8'sd0)       sat_duty = 7'd0;
    else if (v > DMAX_S) sat_duty = 7'd100;
    else                 sat_duty = v[6:0];
  endfunction

  // Index 1 = up key, index 0 = down key.
  logic [1:0]       key_raw;
  logic [1:0]       key_p0;
  logic [1:0]       key_p1;
  logic [1:0]       key_deb;
  logic [DEB_W-1:0] deb_cnt [2];

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             rep;
  logic             dir;
  logic             key_u;
  logic             key_d;
  logic             key_sel;
  logic             key_oth;

  logic signed [FW-1:0] fstep;
  logic signed [FW-1:0] freq_sum;
  logic signed [7:0]    dstep;
  logic signed [7:0]    duty_sum;
  logic [nbits_freq-1:0] freq_new;
  logic [6:0]            duty_new;

  assign key_raw = {iKEY_UP, iKEY_DN};

  // Stage p0/p1: two-flop synchroniser, then per-key debounce
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      key_p0  <= '0;
      key_p1  <= '0;
      key_deb <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      key_p0 <= key_raw;
      key_p1 <= key_p0;
      for (int i = 0; i < 2; i++) begin
        if (key_p1[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_TOP) begin
          deb_cnt[i] <= '0;
          key_deb[i] <= key_p1[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign key_u   = key_deb[1];
  assign key_d   = key_deb[0];
  assign key_sel = dir ? key_u : key_d;
  assign key_oth = dir ? key_d : key_u;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      tmr   <= '0;
      rep   <= 1'b0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        rep <= 1'b0;
        dir <= key_u;
      end else if (state == HOLD && state_nxt == FIRE) begin
        rep <= 1'b1;
      end
      if (state == FIRE)                  tmr <= rep ? RATE_LD : DELAY_LD;
      else if (state == HOLD && tmr != '0) tmr <= tmr - TMR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (key_u && key_d)      state_nxt = LOCK;
        else if (key_u ^ key_d)  state_nxt = FIRE;
      end
      FIRE: state_nxt = HOLD;
      HOLD: begin
        // Releasing the key that started the hold ends it, even if the other key is down.
        if (!key_sel)            state_nxt = IDLE;
        else if (key_oth)        state_nxt = LOCK;
        else if (tmr == '0)      state_nxt = FIRE;
      end
      LOCK: begin
        if (!key_u && !key_d)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fstep    = iCOARSE ? FSTEP_C : FSTEP_F;
    dstep    = iCOARSE ? DSTEP_C : DSTEP_F;
    freq_sum = dir ? ($signed({1'b0, oPWM_freq}) + fstep)
                   : ($signed({1'b0, oPWM_freq}) - fstep);
    duty_sum = dir ? ($signed({1'b0, oduty_cycle}) + dstep)
                   : ($signed({1'b0, oduty_cycle}) - dstep);
    freq_new = sat_freq(freq_sum);
    duty_new = sat_duty(duty_sum);
  end

  // Output stage: registered words, strobe only on a real change
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oPWM_freq   <= FREQ_RST;
      oduty_cycle <= DUTY_RST;
      oUPD        <= 1'b0;
    end else begin
      oUPD <= 1'b0;
      if (state == FIRE) begin
        if (iMODE) begin
          if (freq_new != oPWM_freq) begin
            oPWM_freq <= freq_new;
            oUPD      <= 1'b1;
          end
        end else if (duty_new != oduty_cycle) begin
          oduty_cycle <= duty_new;
          oUPD        <= 1'b1;
        end
      end
    end
  end

endmodule
